// File: rtl/sdram_refresh_ctrl.sv
// SDRAM auto-refresh controller: interval timer, postponed-refresh debt
// bookkeeping, and a PRE -> AREF x REF_BURST command sequencer granted by an arbiter.
module sdram_refresh_ctrl #(
    parameter int REF_INTERVAL = 750,
    parameter int REF_BURST    = 2,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int ADDR_W       = 12,
    parameter int BA_W         = 2,
    parameter int AP_BIT       = 10,
    parameter int MAX_DEBT     = 8,
    parameter int URGENT_LVL   = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flag_init_end,
    input  logic              ref_en,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic              ref_busy,
    output logic [3:0]        cmd_reg,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_bank,
    output logic              flag_ref_end,
    output logic [3:0]        ref_debt,
    output logic              ref_overflow
);
    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int BC_W  = $clog2(REF_BURST + 1);
    localparam int WMAX  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WC_W  = $clog2(WMAX + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        debt_q, debt_d;
    logic              ovf_q, ovf_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              urg_q, urg_d;
    logic              busy_q, busy_d;
    logic              fend_q, fend_d;
    logic              tick, done, last;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        last    = 1'b0;
        start_d = start_q | flag_init_end;
        tick    = start_q && (cnt_q == CNT_W'(REF_INTERVAL - 1));
        cnt_d   = (!start_q || tick) ? '0 : cnt_q + 1'b1;

        // Commands are registered from the current state, so each state's
        // command appears on the bus one cycle after the state is entered.
        case (state_q)
            S_IDLE: begin
                if (start_q && ref_en && debt_q != 4'd0) begin
                    state_d = S_PRE;
                    bcnt_d  = '0;
                end
            end
            S_PRE: begin
                if (T_RP == 1) state_d = S_AREF;
                else begin
                    state_d = S_WAIT_RP;
                    wcnt_d  = WC_W'(T_RP - 2);
                end
            end
            S_WAIT_RP: begin
                if (wcnt_q == '0) state_d = S_AREF;
                else wcnt_d = wcnt_q - 1'b1;
            end
            S_AREF: begin
                bcnt_d = bcnt_q + 1'b1;
                last   = (bcnt_q == BC_W'(REF_BURST - 1));
                if (T_RFC == 1) state_d = last ? S_DONE : S_AREF;
                else begin
                    state_d = S_WAIT_RFC;
                    wcnt_d  = WC_W'(T_RFC - 2);
                end
            end
            S_WAIT_RFC: begin
                if (wcnt_q == '0) state_d = (bcnt_q == BC_W'(REF_BURST)) ? S_DONE : S_AREF;
                else wcnt_d = wcnt_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done   = (state_q == S_DONE);
        debt_d = debt_q;
        if (tick && !done) begin
            if (debt_q != 4'(MAX_DEBT)) debt_d = debt_q + 4'd1;
        end else if (done && !tick) begin
            debt_d = debt_q - 4'd1;
        end
        ovf_d = ovf_q | (tick && debt_q == 4'(MAX_DEBT));

        cmd_d  = CMD_NOP;
        addr_d = '0;
        if (state_q == S_PRE) begin
            cmd_d          = CMD_PRE;
            addr_d[AP_BIT] = 1'b1;
        end else if (state_q == S_AREF) begin
            cmd_d = CMD_AREF;
        end
        busy_d = (state_q != S_IDLE);
        fend_d = done;
        req_d  = (state_d == S_IDLE) && (debt_d != 4'd0);
        urg_d  = (debt_d >= 4'(URGENT_LVL));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            debt_q  <= '0;
            ovf_q   <= 1'b0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            req_q   <= 1'b0;
            urg_q   <= 1'b0;
            busy_q  <= 1'b0;
            fend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            debt_q  <= debt_d;
            ovf_q   <= ovf_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            urg_q   <= urg_d;
            busy_q  <= busy_d;
            fend_q  <= fend_d;
        end
    end

    assign ref_req      = req_q;
    assign ref_urgent   = urg_q;
    assign ref_busy     = busy_q;
    assign cmd_reg      = cmd_q;
    assign sdram_addr   = addr_q;
    assign sdram_bank   = '0;
    assign flag_ref_end = fend_q;
    assign ref_debt     = debt_q;
    assign ref_overflow = ovf_q;
endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Bench for sdram_refresh_ctrl: expected command events are queued at grant
// time and matched by a monitor against the bus, plus timed debt/flag checks.
module tb_sdram_refresh_ctrl;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [4:0] EV_PRE  = 5'b0_0010;
    localparam logic [4:0] EV_AREF = 5'b0_0001;
    localparam logic [4:0] EV_END  = 5'b1_0111;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        flag_init_end = 1'b0;
    logic        ref_en = 1'b0;
    logic        ref_req, ref_urgent, ref_busy, flag_ref_end, ref_overflow;
    logic [3:0]  cmd_reg, ref_debt;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    sdram_refresh_ctrl dut (
        .clk(clk), .rstn(rstn), .flag_init_end(flag_init_end), .ref_en(ref_en),
        .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_busy(ref_busy),
        .cmd_reg(cmd_reg), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .flag_ref_end(flag_ref_end), .ref_debt(ref_debt), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  code;
        logic [11:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every non-NOP command or end pulse must match the queue head.
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (cmd_reg !== NOP || flag_ref_end !== 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_event", {flag_ref_end, cmd_reg}, EV_END & 5'h07);
            else begin
                e = exp_q.pop_front();
                chk("ev_code", {flag_ref_end, cmd_reg}, e.code);
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_addr", sdram_addr, e.addr);
            end
        end else begin
            chk("nop_addr", sdram_addr, 32'h0);
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input logic [4:0] code, input logic [11:0] addr);
        ev_t e;
        e.cyc = c; e.code = code; e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Grant sampled at edge t; full bursts also expect the second AREF and end pulse.
    task automatic grant(input int t, input bit full);
        wait_to(t - 1);
        ref_en = 1'b1;
        push_ev(t + 1, EV_PRE, 12'h400);
        push_ev(t + 3, EV_AREF, 12'h000);
        if (full) begin
            push_ev(t + 10, EV_AREF, 12'h000);
            push_ev(t + 17, EV_END, 12'h000);
        end
    endtask

    initial begin
        int s, t, s2;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_cmd", cmd_reg, NOP);
        chk("rst_debt", ref_debt, 0);
        chk("rst_req", ref_req, 0);
        chk("rst_busy", ref_busy, 0);
        chk("rst_urgent", ref_urgent, 0);
        chk("rst_ovf", ref_overflow, 0);
        chk("rst_bank", sdram_bank, 0);
        rstn = 1'b1;

        // Grant before init must be ignored.
        ref_en = 1'b1;
        wait_to(cyc + 20);
        chk("preinit_debt", ref_debt, 0);
        chk("preinit_req", ref_req, 0);
        ref_en = 1'b0;

        s = cyc + 1;
        flag_init_end = 1'b1;
        @(posedge clk); #1;
        flag_init_end = 1'b0;

        wait_to(s + 749);
        chk("debt_before_tick", ref_debt, 0);
        chk("req_before_tick", ref_req, 0);
        wait_to(s + 750);
        chk("debt_tick1", ref_debt, 1);
        chk("req_tick1", ref_req, 1);
        wait_to(s + 1500);
        chk("debt_tick2", ref_debt, 2);

        // Burst with ref_en held high throughout.
        t = s + 1510;
        grant(t, 1'b1);
        wait_to(t + 5);
        chk("burst_req_low", ref_req, 0);
        chk("burst_busy", ref_busy, 1);
        wait_to(t + 16);
        ref_en = 1'b0;
        wait_to(t + 17);
        chk("burstA_debt", ref_debt, 1);
        chk("burstA_busy_done", ref_busy, 1);
        chk("burstA_req_again", ref_req, 1);
        wait_to(t + 18);
        chk("burstA_busy_off", ref_busy, 0);

        // Single-cycle grant at debt 1.
        t = s + 1540;
        grant(t, 1'b1);
        wait_to(t);
        ref_en = 1'b0;
        wait_to(t + 17);
        chk("burstB_debt", ref_debt, 0);
        chk("burstB_req", ref_req, 0);

        // Completion coincides with the tick at s+3000.
        wait_to(s + 2250);
        chk("debt_tick3", ref_debt, 1);
        t = s + 2983;
        grant(t, 1'b1);
        wait_to(t);
        ref_en = 1'b0;
        wait_to(t + 16);
        chk("coinc_debt_pre", ref_debt, 1);
        wait_to(t + 17);
        chk("coinc_debt", ref_debt, 1);
        chk("coinc_req", ref_req, 1);

        // Debt accumulation, urgency and overflow.
        wait_to(s + 6749);
        chk("urg_before", ref_urgent, 0);
        chk("debt5", ref_debt, 5);
        wait_to(s + 6750);
        chk("urg_rise", ref_urgent, 1);
        chk("debt6", ref_debt, 6);
        wait_to(s + 8250);
        chk("debt8", ref_debt, 8);
        chk("ovf_before", ref_overflow, 0);
        wait_to(s + 9000);
        chk("debt_sat", ref_debt, 8);
        chk("ovf_set", ref_overflow, 1);

        // Reset in the middle of a burst.
        t = s + 9010;
        grant(t, 1'b0);
        wait_to(t);
        ref_en = 1'b0;
        wait_to(t + 5);
        rstn = 1'b0;
        #1;
        chk("abort_cmd", cmd_reg, NOP);
        chk("abort_busy", ref_busy, 0);
        chk("abort_debt", ref_debt, 0);
        chk("abort_ovf", ref_overflow, 0);
        chk("abort_urg", ref_urgent, 0);
        chk("abort_req", ref_req, 0);
        wait_to(t + 12);
        rstn = 1'b1;
        s2 = cyc;
        wait_to(s2 + 800);
        chk("noinit_debt", ref_debt, 0);
        chk("noinit_req", ref_req, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
